// File: rtl/data_ram_slave_pkg.sv
// Shared types and constants for the data RAM responder.
//   data_addr_t / data_t / byte_en_t : bus widths on the mem-stage side
//   DataMemNumLog2                   : default log2 word count of the array
//   dram_state_e                     : responder FSM encoding
//   Be*                              : legal byte-enable patterns
//   be_legal()                       : true for byte, aligned half and full-word strobes
package data_ram_slave_pkg;

    typedef logic [31:0] data_addr_t;
    typedef logic [31:0] data_t;
    typedef logic [3:0]  byte_en_t;

    localparam int unsigned DataMemNumLog2 = 10;

    typedef enum logic [1:0] {
        DRamIdle = 2'd0,
        DRamWait = 2'd1,
        DRamResp = 2'd2
    } dram_state_e;

    localparam byte_en_t BeByte0 = 4'b0001;
    localparam byte_en_t BeByte1 = 4'b0010;
    localparam byte_en_t BeByte2 = 4'b0100;
    localparam byte_en_t BeByte3 = 4'b1000;
    localparam byte_en_t BeHalf0 = 4'b0011;
    localparam byte_en_t BeHalf1 = 4'b1100;
    localparam byte_en_t BeWord  = 4'b1111;

    function automatic logic be_legal(byte_en_t be);
        logic ok;
        case (be)
            BeByte0, BeByte1, BeByte2, BeByte3, BeHalf0, BeHalf1, BeWord: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/data_ram_slave_if.sv
// Request/response channels between the mem stage (master) and the data RAM (slave).
//   req_*  : valid/ready request carrying we, byte address, store data and byte enables
//   resp_* : valid/ready response carrying load data and error flag
interface data_ram_slave_if import data_ram_slave_pkg::*; ();

    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    data_addr_t req_addr;
    data_t      req_wdata;
    byte_en_t   req_be;
    logic       resp_valid;
    logic       resp_ready;
    data_t      resp_rdata;
    logic       resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/data_ram_array.sv
// Word-wide storage with per-lane write enables and a registered (synchronous) read.
//   clk   : clock
//   en    : access strobe; read and lane writes happen only on enabled edges
//   we    : per-byte-lane write enables (bit i = lane i)
//   addr  : word index
//   wdata : lane-aligned write data
//   rdata : word read on the last enabled edge (old contents on a write)
// No reset: contents survive responder reset.
module data_ram_array
    import data_ram_slave_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = DataMemNumLog2
) (
    input  logic                  clk,
    input  logic                  en,
    input  byte_en_t              we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  data_t                 wdata,
    output data_t                 rdata
);

    data_t mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/data_ram_slave.sv
// Data-memory responder for the mem stage: accepts one load/store, waits WAIT_CYCLES,
// then presents a response held until handshaked.
//   clk : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : request/response channels (slave side)
// Errors (address beyond the array, or an illegal strobe) suppress the write and return
// rdata=0 with resp_err=1 at normal latency.
module data_ram_slave
    import data_ram_slave_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2  = DataMemNumLog2,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    data_ram_slave_if.slave bus
);

    localparam logic [3:0] CntInit = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef logic [DEPTH_LOG2-1:0] word_idx_t;

    dram_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, err_q;
    word_idx_t   idx_q;
    data_t       wdata_q;
    byte_en_t    be_q;

    logic        req_ready, accept, enter_resp, req_err;
    logic        cur_we, cur_err;
    word_idx_t   cur_idx;
    data_t       cur_wdata;
    byte_en_t    cur_be, mem_we;
    data_t       mem_rdata, lane_mask;
    logic        unused_addr_lsb;

    // Alignment is carried by req_be only.
    assign unused_addr_lsb = ^bus.req_addr[1:0];

    // Gating with rst keeps req_ready low for the whole reset and blocks array writes.
    assign req_ready = (state_q == DRamIdle) && rst;
    assign accept    = req_ready && bus.req_valid;
    assign req_err   = (bus.req_addr[31:DEPTH_LOG2+2] != '0) || !be_legal(bus.req_be);

    // With no wait states RESP is entered on the acceptance edge, so the array must be
    // driven from the live request in IDLE and from the latched copy otherwise.
    always_comb begin
        if (state_q == DRamIdle) begin
            cur_we    = bus.req_we;
            cur_err   = req_err;
            cur_idx   = bus.req_addr[DEPTH_LOG2+1:2];
            cur_wdata = bus.req_wdata;
            cur_be    = bus.req_be;
        end else begin
            cur_we    = we_q;
            cur_err   = err_q;
            cur_idx   = idx_q;
            cur_wdata = wdata_q;
            cur_be    = be_q;
        end
    end

    assign mem_we = cur_be & {4{cur_we & ~cur_err}};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        unique case (state_q)
            DRamIdle: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d    = DRamResp;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = DRamWait;
                        cnt_d   = CntInit;
                    end
                end
            end
            DRamWait: begin
                if (cnt_q == '0) begin
                    state_d    = DRamResp;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DRamResp: begin
                if (bus.resp_ready) begin
                    state_d = DRamIdle;
                end
            end
            default: state_d = DRamIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DRamIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            err_q   <= req_err;
            idx_q   <= bus.req_addr[DEPTH_LOG2+1:2];
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
        end
    end

    data_ram_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .en   (enter_resp),
        .we   (mem_we),
        .addr (cur_idx),
        .wdata(cur_wdata),
        .rdata(mem_rdata)
    );

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < 4; i++) begin
            lane_mask[8*i +: 8] = {8{be_q[i]}};
        end
    end

    // Array output only changes on enabled edges, so these stay stable through RESP.
    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = (state_q == DRamResp);
    assign bus.resp_err   = (state_q == DRamResp) && err_q;
    assign bus.resp_rdata = ((state_q == DRamResp) && !we_q && !err_q) ?
                            (mem_rdata & lane_mask) : '0;

endmodule

// File: tb/tb_data_ram_slave.sv
// Bench for data_ram_slave: three instances with WAIT_CYCLES 1, 0 and 3 share clock and
// reset. A monitor holds a word-array model and checks every instance on every falling
// edge; the main sequence adds literal expectations for each directed vector.
module tb_data_ram_slave;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]        t_valid, t_we, t_resp_ready;
    logic [2:0][31:0]  t_addr, t_wdata;
    logic [2:0][3:0]   t_be;
    logic [2:0]        o_ready, o_rvalid, o_err;
    logic [2:0][31:0]  o_rdata;

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned W = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        data_ram_slave_if bus ();
        assign bus.req_valid  = t_valid[g];
        assign bus.req_we     = t_we[g];
        assign bus.req_addr   = t_addr[g];
        assign bus.req_wdata  = t_wdata[g];
        assign bus.req_be     = t_be[g];
        assign bus.resp_ready = t_resp_ready[g];
        assign o_ready[g]     = bus.req_ready;
        assign o_rvalid[g]    = bus.resp_valid;
        assign o_rdata[g]     = bus.resp_rdata;
        assign o_err[g]       = bus.resp_err;
        data_ram_slave #(
            .DEPTH_LOG2 (10),
            .WAIT_CYCLES(W)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus)
        );
    end

    function automatic int wc(int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // ---------------- model ----------------
    logic [31:0] mdl [3][1024];
    bit          pend [3];
    bit          seen [3];
    int          age  [3];
    logic        sn_we [3];
    logic [31:0] sn_addr [3];
    logic [31:0] sn_wdata [3];
    logic [3:0]  sn_be [3];
    logic [31:0] exp_rd [3];
    logic        exp_err [3];

    function automatic bit m_err(logic [31:0] addr, logic [3:0] be);
        return (addr >= 32'h0000_1000) ||
               !(be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
    endfunction

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                pend[k] = 1'b0;
                chk($sformatf("w%0d_rst_rvalid", k), 32'(o_rvalid[k]), 32'd0);
                chk($sformatf("w%0d_rst_ready", k), 32'(o_ready[k]), 32'd0);
                chk($sformatf("w%0d_rst_rdata", k), o_rdata[k], 32'd0);
                chk($sformatf("w%0d_rst_err", k), 32'(o_err[k]), 32'd0);
            end else if (pend[k]) begin
                age[k]++;
                chk($sformatf("w%0d_busy_ready", k), 32'(o_ready[k]), 32'd0);
                chk($sformatf("w%0d_valid_timing", k), 32'(o_rvalid[k]),
                    32'(age[k] >= wc(k) + 1));
                if (o_rvalid[k]) begin
                    if (!seen[k]) begin
                        seen[k]    = 1'b1;
                        exp_rd[k]  = 32'd0;
                        exp_err[k] = m_err(sn_addr[k], sn_be[k]);
                        if (!exp_err[k]) begin
                            for (int i = 0; i < 4; i++) begin
                                if (sn_be[k][i]) begin
                                    if (sn_we[k])
                                        mdl[k][sn_addr[k][11:2]][8*i +: 8] = sn_wdata[k][8*i +: 8];
                                    else
                                        exp_rd[k][8*i +: 8] = mdl[k][sn_addr[k][11:2]][8*i +: 8];
                                end
                            end
                        end
                    end
                    chk($sformatf("w%0d_rdata", k), o_rdata[k], exp_rd[k]);
                    chk($sformatf("w%0d_err", k), 32'(o_err[k]), 32'(exp_err[k]));
                    if (t_resp_ready[k]) pend[k] = 1'b0;
                end
            end else begin
                chk($sformatf("w%0d_idle_ready", k), 32'(o_ready[k]), 32'd1);
                chk($sformatf("w%0d_idle_rvalid", k), 32'(o_rvalid[k]), 32'd0);
                if (t_valid[k]) begin
                    pend[k]     = 1'b1;
                    seen[k]     = 1'b0;
                    age[k]      = 0;
                    sn_we[k]    = t_we[k];
                    sn_addr[k]  = t_addr[k];
                    sn_wdata[k] = t_wdata[k];
                    sn_be[k]    = t_be[k];
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic issue(input int k, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        bit acc = 1'b0;
        int n = 0;
        t_we[k] = we; t_addr[k] = addr; t_wdata[k] = wdata; t_be[k] = be; t_valid[k] = 1'b1;
        while (!acc && n < 20) begin
            acc = o_ready[k];
            @(posedge clk); #2;
            n++;
        end
        chk($sformatf("w%0d_accept", k), 32'(acc), 32'd1);
        // Scramble request fields: they must only be sampled at acceptance.
        t_valid[k] = 1'b0;
        t_we[k]    = 1'($urandom);
        t_addr[k]  = $urandom;
        t_wdata[k] = $urandom;
        t_be[k]    = 4'($urandom);
    endtask

    task automatic xact(input int k, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        output logic [31:0] rd, output logic err, output int lat);
        issue(k, we, addr, wdata, be);
        lat = 1;
        while (!o_rvalid[k] && lat < 40) begin
            @(posedge clk); #2;
            lat++;
        end
        rd  = o_rdata[k];
        err = o_err[k];
        if (t_resp_ready[k]) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic expect_resp(input string name, input logic [31:0] rd, input logic err,
                               input int lat, input logic [31:0] e_rd, input logic e_err,
                               input int e_lat);
        chk({name, "_rdata"}, rd, e_rd);
        chk({name, "_err"}, 32'(err), 32'(e_err));
        chk({name, "_lat"}, lat, e_lat);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;

        t_valid = '0; t_we = '0; t_addr = '0; t_wdata = '0; t_be = '0;
        t_resp_ready = '1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk); #2;

        // Word store/load, one wait state.
        xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, rd, err, lat);
        expect_resp("st_word", rd, err, lat, 32'h0, 1'b0, 2);
        xact(0, 1'b0, 32'h10, 32'h0, 4'b1111, rd, err, lat);
        expect_resp("ld_word", rd, err, lat, 32'hDEADBEEF, 1'b0, 2);

        // Byte store then lane-masked loads; low address bits ignored.
        xact(0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, rd, err, lat);
        expect_resp("st_byte", rd, err, lat, 32'h0, 1'b0, 2);
        xact(0, 1'b0, 32'h10, 32'h0, 4'b1111, rd, err, lat);
        expect_resp("ld_after_byte", rd, err, lat, 32'hDEADBEAA, 1'b0, 2);
        xact(0, 1'b0, 32'h10, 32'h0, 4'b1100, rd, err, lat);
        expect_resp("ld_upper_half", rd, err, lat, 32'hDEAD0000, 1'b0, 2);
        xact(0, 1'b0, 32'h13, 32'h0, 4'b0010, rd, err, lat);
        expect_resp("ld_unaligned_addr", rd, err, lat, 32'h0000BE00, 1'b0, 2);

        // Latency sweep on the 0- and 3-wait instances.
        xact(1, 1'b1, 32'h100, 32'h12345678, 4'b1111, rd, err, lat);
        expect_resp("w0_st", rd, err, lat, 32'h0, 1'b0, 1);
        xact(1, 1'b0, 32'h100, 32'h0, 4'b1111, rd, err, lat);
        expect_resp("w0_ld", rd, err, lat, 32'h12345678, 1'b0, 1);
        xact(2, 1'b1, 32'h100, 32'hCAFEF00D, 4'b1111, rd, err, lat);
        expect_resp("w3_st", rd, err, lat, 32'h0, 1'b0, 4);
        xact(2, 1'b0, 32'h100, 32'h0, 4'b0011, rd, err, lat);
        expect_resp("w3_ld_half", rd, err, lat, 32'h0000F00D, 1'b0, 4);

        // Backpressure: response held, competing request ignored.
        t_resp_ready[0] = 1'b0;
        xact(0, 1'b0, 32'h10, 32'h0, 4'b1111, rd, err, lat);
        expect_resp("bp_ld", rd, err, lat, 32'hDEADBEAA, 1'b0, 2);
        t_we[0] = 1'b1; t_addr[0] = 32'h10; t_wdata[0] = 32'h0; t_be[0] = 4'b1111;
        t_valid[0] = 1'b1;
        repeat (5) begin
            @(posedge clk); #2;
            chk("bp_hold_valid", 32'(o_rvalid[0]), 32'd1);
            chk("bp_hold_rdata", o_rdata[0], 32'hDEADBEAA);
            chk("bp_hold_ready", 32'(o_ready[0]), 32'd0);
        end
        t_valid[0] = 1'b0;
        t_resp_ready[0] = 1'b1;
        @(posedge clk); #2;
        chk("bp_ready_after", 32'(o_ready[0]), 32'd1);
        xact(0, 1'b0, 32'h10, 32'h0, 4'b1111, rd, err, lat);
        expect_resp("bp_store_ignored", rd, err, lat, 32'hDEADBEAA, 1'b0, 2);

        // Range and strobe errors.
        xact(0, 1'b0, 32'h00001000, 32'h0, 4'b1111, rd, err, lat);
        expect_resp("range_err", rd, err, lat, 32'h0, 1'b1, 2);
        xact(0, 1'b1, 32'h20, 32'h11223344, 4'b1111, rd, err, lat);
        expect_resp("st_0x20", rd, err, lat, 32'h0, 1'b0, 2);
        xact(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'b0101, rd, err, lat);
        expect_resp("strobe_err", rd, err, lat, 32'h0, 1'b1, 2);
        xact(0, 1'b0, 32'h20, 32'h0, 4'b1111, rd, err, lat);
        expect_resp("after_strobe_err", rd, err, lat, 32'h11223344, 1'b0, 2);
        xact(2, 1'b1, 32'h80000010, 32'hFFFFFFFF, 4'b1111, rd, err, lat);
        expect_resp("w3_range_err_st", rd, err, lat, 32'h0, 1'b1, 4);

        // Reset one cycle into WAIT drops the uncommitted store.
        xact(2, 1'b1, 32'h40, 32'hA5A5A5A5, 4'b1111, rd, err, lat);
        expect_resp("st_0x40", rd, err, lat, 32'h0, 1'b0, 4);
        issue(2, 1'b1, 32'h40, 32'h00000055, 4'b1111);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("rst_async_rvalid", 32'(o_rvalid[2]), 32'd0);
        chk("rst_async_ready", 32'(o_ready[2]), 32'd0);
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("rst_release_ready", 32'(o_ready[2]), 32'd1);
        @(posedge clk); #2;
        xact(2, 1'b0, 32'h40, 32'h0, 4'b1111, rd, err, lat);
        expect_resp("ld_after_rst", rd, err, lat, 32'hA5A5A5A5, 1'b0, 4);
        xact(0, 1'b0, 32'h10, 32'h0, 4'b1111, rd, err, lat);
        expect_resp("mem_kept_over_rst", rd, err, lat, 32'hDEADBEAA, 1'b0, 2);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_ram_slave.md
Name: data_ram_slave

Overview:
- Data-memory responder serving load/store requests from the mem stage through a valid/ready request channel and a valid/ready response channel.
- Replaces the pass-through memory path with a real memory endpoint that has configurable wait states, byte strobes and error reporting.
- Sits beside regfile and inst_rom under xcore, on the far side of the mem stage.

Parameters:
- DEPTH_LOG2, 10, log2 of word count (1024 x 32-bit words = 4 KiB).
- WAIT_CYCLES, 1, extra cycles between request acceptance and response (0..15 legal).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address; bits [1:0] ignored, word index = addr[DEPTH_LOG2+1:2].
- req_wdata  in  32  store data, lane-aligned.
- req_be  in  4  byte enables, bit i = byte lane i.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts response.
- resp_rdata  out  32  load data; non-enabled lanes read 0; 0 for stores and errors.
- resp_err  out  1  request rejected (range or strobe error).

Behaviour:
- Reset (rst low, async): FSM -> IDLE, req_ready=0 while asserted, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. Memory array is not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch we/addr/wdata/be.
  - Go to WAIT with counter=WAIT_CYCLES-1, or directly to RESP if WAIT_CYCLES==0.
- WAIT:
  - req_ready=0; counter decrements each cycle.
  - When counter==0: load the response registers and go to RESP.
- RESP:
  - resp_valid=1; outputs held stable until resp_valid&&resp_ready, then go to IDLE.
  - No same-cycle acceptance of a new request; req_ready is 0 in RESP.
- Latency: resp_valid rises exactly WAIT_CYCLES+1 cycles after the acceptance edge. Minimum issue interval is WAIT_CYCLES+2 cycles with resp_ready tied high.
- Store commit:
  - Enabled byte lanes are written on the clock edge that enters RESP; disabled lanes are unchanged.
  - resp_rdata=0, resp_err=0.
- Load:
  - Word read on the edge entering RESP.
  - resp_rdata lane i = mem byte i if be[i], else 8'h00.
- Errors:
  - Range error: req_addr[31:DEPTH_LOG2+2] != 0.
  - Strobe error: be not in {0001, 0010, 0100, 1000, 0011, 1100, 1111}.
  - On error: no write, resp_rdata=0, resp_err=1; latency unchanged.
- Backpressure: if resp_ready stays low in RESP, all response outputs are held indefinitely and req_ready stays 0.
- req_valid deasserted before acceptance: no effect. Inputs are sampled only at the acceptance edge; later changes are ignored.
- Reset mid-transaction:
  - Reset in WAIT aborts; a store not yet committed is dropped.
  - Reset in RESP discards the response; a store already committed remains in memory.
- Address bits [1:0] never cause an error; alignment is expressed only through be.

Decomposition:
- defines.v gains:
  - DataAddrBus 31:0, DataBus 31:0, ByteEnBus 3:0.
  - DataMemNumLog2 (default 10).
  - State encodings DRamIdle/DRamWait/DRamResp (2 bits).
  - Legal byte-enable constants.
- One natural sub-module: data_ram_array.
  - Word-wide array with 4 per-lane write enables and synchronous read.
  - Contains no reset logic; holds all storage.
- The FSM, counter, error checks and lane masking stay in data_ram_slave.

Test Plan:
- Word store/load, WAIT_CYCLES=1: store addr 0x10 data 0xDEADBEEF be 1111, then load 0x10 be 1111 -> resp_rdata=0xDEADBEEF, resp_err=0, resp_valid 2 cycles after each acceptance.
- Byte/half lanes: after the above, store 0x000000AA be 0001 at 0x10, then load be 1111 -> 0xDEADBEAA; load be 1100 -> 0xDEAD0000.
- Latency sweep, WAIT_CYCLES=0 and 3: measure acceptance-to-resp_valid -> exactly 1 and 4 cycles; req_ready=0 throughout.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_rdata and resp_err stable, req_valid ignored; one cycle after the handshake, req_ready=1.
- Errors:
  - Load 0x00001000 with DEPTH_LOG2=10 -> resp_err=1, rdata=0.
  - Store be 0101 to 0x20 -> resp_err=1, and a subsequent load of 0x20 returns the prior contents.
- Reset mid-wait, WAIT_CYCLES=3: store 0x55 to 0x40, assert rst low 1 cycle after acceptance -> resp_valid=0 immediately (async); after release, load of 0x40 returns the old value and req_ready=1.
